// File: rtl/wb_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_scoreboard_pkg
//  Brief    : Shared defines for the write-back scoreboard: tracked-target
//             indices, counter sizing and target-match helper.
//  Revision : 1.0 - initial release
// ============================================================================
package wb_scoreboard_pkg;

    localparam int   ADDR_W        = 7;
    localparam int   NUM_TRK       = 35;
    localparam int   CNT_W_DEFAULT = 2;
    localparam int   IDX_HI        = 32;
    localparam int   IDX_LO        = 33;
    localparam int   IDX_CP0       = 34;
    localparam logic COND_FLOW     = 1'b1;

    // HI/LO pair writes ignore the address; index 0 is never a target.
    function automatic logic tgt_hit(input logic [ADDR_W-1:0] addr,
                                     input logic              hilo,
                                     input int                idx);
        if (hilo)
            return (idx == IDX_HI) || (idx == IDX_LO);
        return (idx != 0) && (int'(addr) == idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_scoreboard_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sb_counter
//  Brief    : Saturating up/down pending-write counter with clear.
//  Revision : 1.0 - initial release
// ============================================================================
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && !dec && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (dec && !inc && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign cnt       = r_cnt;
    assign underflow = dec & ~inc & (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : wb_scoreboard
//  Brief    : Per-register pending-write scoreboard for decode interlock,
//             with write-through on commit and sticky underflow error.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_scoreboard
    import wb_scoreboard_pkg::*;
#(
    parameter int CNT_W   = wb_scoreboard_pkg::CNT_W_DEFAULT,
    parameter int NUM_TRK = wb_scoreboard_pkg::NUM_TRK
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 issue_valid,
    input  logic [wb_scoreboard_pkg::ADDR_W-1:0] issue_waddr,
    input  logic                                 issue_hilo,
    input  logic                                 wb_valid,
    input  logic [wb_scoreboard_pkg::ADDR_W-1:0] wb_waddr,
    input  logic                                 wb_hilo,
    input  logic                                 rs_ren,
    input  logic                                 rt_ren,
    input  logic [wb_scoreboard_pkg::ADDR_W-1:0] rs_addr,
    input  logic [wb_scoreboard_pkg::ADDR_W-1:0] rt_addr,
    input  logic                                 flush,
    output logic                                 busy_rs,
    output logic                                 busy_rt,
    output logic                                 stall,
    output logic                                 err
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [CNT_W-1:0]   w_cnt [NUM_TRK];
    logic [NUM_TRK-1:0] w_tgt;
    logic [NUM_TRK-1:0] w_dec;
    logic [NUM_TRK-1:0] w_sat;
    logic [NUM_TRK-1:0] w_uf;
    logic [CNT_W-1:0]   w_rs_eff;
    logic [CNT_W-1:0]   w_rt_eff;
    logic               w_busy_rs;
    logic               w_busy_rt;
    logic               w_stall;
    logic               w_accept;
    logic               r_err;

    always_comb begin
        w_tgt = '0;
        w_dec = '0;
        for (int i = 1; i < NUM_TRK; i++) begin
            w_tgt[i] = tgt_hit(issue_waddr, issue_hilo, i);
            w_dec[i] = wb_valid & tgt_hit(wb_waddr, wb_hilo, i);
        end
    end

    generate
        for (genvar i = 0; i < NUM_TRK; i++) begin : g_trk
            if (i == 0) begin : g_zero
                assign w_cnt[i] = '0;
                assign w_sat[i] = 1'b0;
                assign w_uf[i]  = 1'b0;
            end else begin : g_cnt
                sb_counter #(
                    .CNT_W (CNT_W)
                ) u_cnt (
                    .clk       (clk),
                    .rst       (rst),
                    .inc       (w_tgt[i] & w_accept),
                    .dec       (w_dec[i]),
                    .clr       (flush),
                    .cnt       (w_cnt[i]),
                    .underflow (w_uf[i])
                );
                // A same-cycle commit frees a slot, so a full counter may still accept.
                assign w_sat[i] = (w_cnt[i] == c_cnt_max) & ~w_dec[i];
            end
        end
    endgenerate

    // Read lookup sees the count net of this cycle's commit (write-through).
    always_comb begin
        w_rs_eff = '0;
        w_rt_eff = '0;
        for (int i = 0; i < NUM_TRK; i++) begin
            if (rs_addr == ADDR_W'(i))
                w_rs_eff = w_dec[i] ? (w_cnt[i] - 1'b1) : w_cnt[i];
            if (rt_addr == ADDR_W'(i))
                w_rt_eff = w_dec[i] ? (w_cnt[i] - 1'b1) : w_cnt[i];
        end
    end

    assign w_busy_rs = rst & rs_ren & (w_rs_eff != '0);
    assign w_busy_rt = rst & rt_ren & (w_rt_eff != '0);
    assign w_stall   = rst & (w_busy_rs | w_busy_rt | (issue_valid & |(w_tgt & w_sat)));
    assign w_accept  = issue_valid & ~w_stall & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (|w_uf) begin
            r_err <= 1'b1;
        end
    end

    assign busy_rs = w_busy_rs;
    assign busy_rt = w_busy_rt;
    assign stall   = w_stall;
    assign err     = r_err;

endmodule
`default_nettype wire
